// File: rtl/mul_issue_ctrl_if.sv
// mul_issue_ctrl_if: issue, multiplier and writeback signals of the MUL issue
// controller. The controller takes the master modport, its environment
// (issue stage, multiplier array, writeback port) takes the slave modport.
//
// Handshake semantics: a transfer happens on a mul_clk edge where the
// producer's valid and the consumer's ready are both 1. The producer holds
// valid and its payload stable until that edge, and ready never depends on
// valid combinationally. Issue side: ex_valid/ex_ready, payload
// ex_op/ex_src1/ex_src2/ex_dest; writeback side: wb_valid/wb_ready, payload
// wb_dest/wb_data. ex_flush is a kill, not a handshake: it is honoured on
// any edge where it is 1.
interface mul_issue_ctrl_if;
  // issue side
  logic        ex_valid;
  logic [1:0]  ex_op;
  logic [31:0] ex_src1;
  logic [31:0] ex_src2;
  logic [4:0]  ex_dest;
  logic        ex_flush;
  logic        ex_ready;
  // multiplier side
  logic        mul_start;
  logic        mul_sign;
  logic [31:0] mul_x;
  logic [31:0] mul_y;
  logic [63:0] mul_result;
  // writeback side
  logic        wb_valid;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        wb_ready;

  modport master (
    input  ex_valid, ex_op, ex_src1, ex_src2, ex_dest, ex_flush,
    input  mul_result, wb_ready,
    output ex_ready, mul_start, mul_sign, mul_x, mul_y,
    output wb_valid, wb_dest, wb_data
  );

  modport slave (
    output ex_valid, ex_op, ex_src1, ex_src2, ex_dest, ex_flush,
    output mul_result, wb_ready,
    input  ex_ready, mul_start, mul_sign, mul_x, mul_y,
    input  wb_valid, wb_dest, wb_data
  );
endinterface

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: sequences one MUL-class instruction at a time through an
// external fixed-latency multiplier and hands the selected 32-bit result to
// writeback. Ops: 00 MUL.W (low word, signed), 01 MULH.W (high word, signed),
// 10 MULH.WU (high word, unsigned), 11 reserved (completes with 0, no multiply).
//
// Optional build macro MUL_RESULT_CACHE_EN: remembers the last completed
// {src1, src2, sign} and its 64-bit product; a matching instruction skips the
// multiplier and goes straight to writeback.
//
// MUL_LAT (>= 1) is the number of mul_clk edges from the edge that samples
// mul_start to the edge that captures mul_result.
module mul_issue_ctrl #(
  parameter int MUL_LAT = 4
) (
  input  logic                  mul_clk,
  input  logic                  reset,
  mul_issue_ctrl_if.master      bus,
  output logic [2:0]            state_dbg
);

  localparam int CNT_W = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      src1_q;
  logic [31:0]      src2_q;
  logic [1:0]       op_q;
  logic [4:0]       dest_q;
  logic             sign_q;
  logic             start_q;
  logic             wb_valid_q;
  logic [31:0]      wb_data_q;
  logic             accept;
  logic             capture;

  // MUL.W returns the low word, both MULH flavours the high word.
  function automatic logic [31:0] pick_word(input logic [1:0] op, input logic [63:0] prod);
    return (op == 2'b00) ? prod[31:0] : prod[63:32];
  endfunction

  // Only IDLE offers ready; it drops the moment reset is asserted.
  assign bus.ex_ready = reset && (state == IDLE);
  assign accept       = bus.ex_valid && !bus.ex_flush && (state == IDLE);
  // Product is taken on the last counted WAIT edge unless the op is killed.
  assign capture      = (state == WAIT) && (cnt == CNT_ONE) && !bus.ex_flush;

`ifdef MUL_RESULT_CACHE_EN
  logic        cache_vld;
  logic [31:0] cache_src1;
  logic [31:0] cache_src2;
  logic        cache_sign;
  logic [63:0] cache_prod;
  logic        cache_hit;

  // Hit when the offered operands and signedness match the stored entry.
  always_comb begin
    cache_hit = cache_vld &&
                (cache_src1 == bus.ex_src1) &&
                (cache_src2 == bus.ex_src2) &&
                (cache_sign == (bus.ex_op != 2'b10));
  end

  // Store only products that actually completed; drained/flushed ones never land here.
  always_ff @(posedge mul_clk or negedge reset) begin
    if (!reset) begin
      cache_vld  <= 1'b0;
      cache_src1 <= '0;
      cache_src2 <= '0;
      cache_sign <= 1'b0;
      cache_prod <= '0;
    end else if (capture) begin
      cache_vld  <= 1'b1;
      cache_src1 <= src1_q;
      cache_src2 <= src2_q;
      cache_sign <= sign_q;
      cache_prod <= bus.mul_result;
    end
  end
`endif

  // Issue FSM: accept, pulse start, count latency, hold result for writeback.
  always_ff @(posedge mul_clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      op_q       <= '0;
      dest_q     <= '0;
      sign_q     <= 1'b0;
      start_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
    end else begin
      start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            src1_q <= bus.ex_src1;
            src2_q <= bus.ex_src2;
            op_q   <= bus.ex_op;
            dest_q <= bus.ex_dest;
            // Signed for MUL.W/MULH.W; reserved op leaves sign low.
            sign_q <= (bus.ex_op == 2'b00) || (bus.ex_op == 2'b01);
            if (bus.ex_op == 2'b11) begin
              state      <= DONE;
              wb_valid_q <= 1'b1;
              wb_data_q  <= '0;
            end
`ifdef MUL_RESULT_CACHE_EN
            else if (cache_hit) begin
              state      <= DONE;
              wb_valid_q <= 1'b1;
              wb_data_q  <= pick_word(bus.ex_op, cache_prod);
            end
`endif
            else begin
              state   <= ISSUE;
              start_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          // The multiplier samples start on this edge, so latency counting begins here.
          cnt   <= LAT_LOAD;
          state <= bus.ex_flush ? DRAIN : WAIT;
        end
        WAIT: begin
          if (cnt == CNT_ONE) begin
            cnt <= '0;
            if (bus.ex_flush) begin
              state <= IDLE;
            end else begin
              state      <= DONE;
              wb_valid_q <= 1'b1;
              wb_data_q  <= pick_word(op_q, bus.mul_result);
            end
          end else begin
            cnt <= cnt - 1'b1;
            if (bus.ex_flush) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Let the multiplier finish the killed op before accepting another.
          if (cnt <= CNT_ONE) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (bus.ex_flush || bus.wb_ready) begin
            wb_valid_q <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mul_start = start_q;
  assign bus.mul_sign  = sign_q;
  assign bus.mul_x     = src1_q;
  assign bus.mul_y     = src2_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_dest   = dest_q;
  assign bus.wb_data   = wb_data_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: directed bench for mul_issue_ctrl with a behavioural
// fixed-latency multiplier. Define MUL_RESULT_CACHE_EN to also exercise the
// result cache.
module tb_mul_issue_ctrl;

  localparam int MUL_LAT = 4;

  logic       mul_clk;
  logic       reset;
  logic [2:0] state_dbg;

  mul_issue_ctrl_if bus ();

  mul_issue_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .mul_clk   (mul_clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int n_vec = 0;
  int n_bad = 0;
  int n_start = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial mul_clk = 1'b0;
  always #5 mul_clk = ~mul_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- multiplier model ----------------
  logic [63:0] m_prod;
  int          m_lat;

  always @(posedge mul_clk or negedge reset) begin
    if (!reset) begin
      m_prod <= '0;
      m_lat  <= 0;
    end else if (bus.mul_start) begin
      if (bus.mul_sign)
        m_prod <= {{32{bus.mul_x[31]}}, bus.mul_x} * {{32{bus.mul_y[31]}}, bus.mul_y};
      else
        m_prod <= {32'b0, bus.mul_x} * {32'b0, bus.mul_y};
      m_lat <= MUL_LAT;
    end else if (m_lat > 0) begin
      m_lat <= m_lat - 1;
    end
  end

  // Product is only presented on the cycle before the capturing edge.
  assign bus.mul_result = (m_lat == 1) ? m_prod : 64'hDEAD_BEEF_0BAD_F00D;

  always @(posedge mul_clk) begin
    if (bus.mul_start) n_start <= n_start + 1;
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ex_ready"},  bus.ex_ready,  0);
    check_eq({tag, "_mul_start"}, bus.mul_start, 0);
    check_eq({tag, "_mul_sign"},  bus.mul_sign,  0);
    check_eq({tag, "_mul_x"},     bus.mul_x,     0);
    check_eq({tag, "_mul_y"},     bus.mul_y,     0);
    check_eq({tag, "_wb_valid"},  bus.wb_valid,  0);
    check_eq({tag, "_wb_dest"},   bus.wb_dest,   0);
    check_eq({tag, "_wb_data"},   bus.wb_data,   0);
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(negedge mul_clk);
  endtask

  task automatic drive_idle();
    bus.ex_valid = 1'b0;
    bus.ex_op    = 2'b00;
    bus.ex_src1  = '0;
    bus.ex_src2  = '0;
    bus.ex_dest  = '0;
    bus.ex_flush = 1'b0;
  endtask

  // Offer one instruction; returns on the first cycle after the accept edge.
  task automatic accept(input string tag, input logic [1:0] op, input logic [31:0] s1,
                        input logic [31:0] s2, input logic [4:0] d);
    check_eq({tag, "_acc_rdy"}, bus.ex_ready, 1);
    bus.ex_valid = 1'b1;
    bus.ex_op    = op;
    bus.ex_src1  = s1;
    bus.ex_src2  = s2;
    bus.ex_dest  = d;
    tick();
    bus.ex_valid = 1'b0;
  endtask

  // Full-latency path timeline; returns on the first DONE cycle (MUL_LAT+2 after accept).
  task automatic miss_path(input string tag, input logic sg, input logic [31:0] s1,
                           input logic [31:0] s2, input logic [31:0] exp, input logic [4:0] d);
    check_eq({tag, "_start_k1"}, bus.mul_start, 1);
    check_eq({tag, "_sign"},     bus.mul_sign,  sg);
    check_eq({tag, "_x"},        bus.mul_x,     s1);
    check_eq({tag, "_y"},        bus.mul_y,     s2);
    check_eq({tag, "_rdy_busy"}, bus.ex_ready,  0);
    tick();
    check_eq({tag, "_start_k2"}, bus.mul_start, 0);
    repeat (MUL_LAT - 1) tick();
    check_eq({tag, "_wbv_early"}, bus.wb_valid, 0);
    tick();
    check_eq({tag, "_wbv"},  bus.wb_valid, 1);
    check_eq({tag, "_data"}, bus.wb_data,  exp);
    check_eq({tag, "_dest"}, bus.wb_dest,  d);
  endtask

  // Consume the writeback (wb_ready already 1) against the scoreboard.
  task automatic wb_take(input string tag);
    logic [31:0] e;
    check_eq({tag, "_sb_pending"}, exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq({tag, "_sb_data"}, bus.wb_data, e);
    end
    tick();
    check_eq({tag, "_wbv_off"}, bus.wb_valid, 0);
    check_eq({tag, "_rdy_on"},  bus.ex_ready, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s0;
    reset = 1'b0;
    drive_idle();
    bus.wb_ready = 1'b1;
    repeat (2) tick();
    check_all_zero("rst");
    check_eq("rst_state", state_dbg, 0);
    reset = 1'b1;
    #1;
    check_eq("rel_rdy", bus.ex_ready, 1);

    // MUL.W 3 x -1
    accept("mulw", 2'b00, 32'h0000_0003, 32'hFFFF_FFFF, 5'd5);
    exp_q.push_back(32'hFFFF_FFFD);
    miss_path("mulw", 1'b1, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 5'd5);
    wb_take("mulw");

    // MULH.WU 3 x 0xFFFFFFFF
    accept("mulhwu", 2'b10, 32'h0000_0003, 32'hFFFF_FFFF, 5'd6);
    exp_q.push_back(32'h0000_0002);
    miss_path("mulhwu", 1'b0, 32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0002, 5'd6);
    wb_take("mulhwu");

    // MULH.W 3 x -1
    accept("mulhw", 2'b01, 32'h0000_0003, 32'hFFFF_FFFF, 5'd7);
    exp_q.push_back(32'hFFFF_FFFF);
    miss_path("mulhw", 1'b1, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
    wb_take("mulhw");

    // Reserved op: DONE next cycle with zero, no multiply
    s0 = n_start;
    accept("rsv", 2'b11, 32'h0000_0009, 32'h0000_0009, 5'd8);
    exp_q.push_back(32'h0);
    check_eq("rsv_start", bus.mul_start, 0);
    check_eq("rsv_wbv",   bus.wb_valid,  1);
    check_eq("rsv_data",  bus.wb_data,   0);
    check_eq("rsv_dest",  bus.wb_dest,   8);
    wb_take("rsv");
    check_eq("rsv_nstart", n_start - s0, 0);

    // Flush together with valid in IDLE: not accepted
    s0 = n_start;
    bus.ex_valid = 1'b1;
    bus.ex_flush = 1'b1;
    bus.ex_src1  = 32'h4;
    bus.ex_src2  = 32'h4;
    tick();
    drive_idle();
    check_eq("idleflush_rdy",   bus.ex_ready,  1);
    check_eq("idleflush_start", bus.mul_start, 0);
    tick();
    check_eq("idleflush_nstart", n_start - s0, 0);

    // Writeback backpressure for 5 DONE cycles
    bus.wb_ready = 1'b0;
    accept("bp", 2'b00, 32'h0000_0010, 32'h0000_0020, 5'd9);
    exp_q.push_back(32'h0000_0200);
    miss_path("bp", 1'b1, 32'h0000_0010, 32'h0000_0020, 32'h0000_0200, 5'd9);
    repeat (4) begin
      tick();
      check_eq("bp_hold_wbv",  bus.wb_valid, 1);
      check_eq("bp_hold_data", bus.wb_data,  32'h0000_0200);
      check_eq("bp_hold_dest", bus.wb_dest,  9);
      check_eq("bp_hold_rdy",  bus.ex_ready, 0);
    end
    bus.wb_ready = 1'b1;
    wb_take("bp");

    // Flush in the second WAIT cycle: drain without writeback or new start
    s0 = n_start;
    accept("fw", 2'b00, 32'h0000_0007, 32'h0000_0009, 5'd10);
    tick();
    tick();
    bus.ex_flush = 1'b1;
    tick();
    bus.ex_flush = 1'b0;
    check_eq("fw_rdy_k4", bus.ex_ready, 0);
    check_eq("fw_wbv_k4", bus.wb_valid, 0);
    bus.ex_valid = 1'b1;
    bus.ex_src1  = 32'h1;
    bus.ex_src2  = 32'h1;
    tick();
    check_eq("fw_rdy_k5",   bus.ex_ready,  0);
    check_eq("fw_wbv_k5",   bus.wb_valid,  0);
    check_eq("fw_start_k5", bus.mul_start, 0);
    drive_idle();
    tick();
    check_eq("fw_rdy_k6",  bus.ex_ready, 1);
    check_eq("fw_wbv_k6",  bus.wb_valid, 0);
    check_eq("fw_nstart",  n_start - s0, 1);

    // Same operands again must run the full multiply (drained product not kept)
    accept("rerun", 2'b00, 32'h0000_0007, 32'h0000_0009, 5'd10);
    exp_q.push_back(32'h0000_003F);
    miss_path("rerun", 1'b1, 32'h0000_0007, 32'h0000_0009, 32'h0000_003F, 5'd10);
    wb_take("rerun");

    // Flush in DONE drops wb_valid next cycle
    bus.wb_ready = 1'b0;
    accept("fd", 2'b10, 32'h0000_0100, 32'h0000_0100, 5'd11);
    miss_path("fd", 1'b0, 32'h0000_0100, 32'h0000_0100, 32'h0000_0000, 5'd11);
    bus.ex_flush = 1'b1;
    tick();
    bus.ex_flush = 1'b0;
    check_eq("fd_wbv", bus.wb_valid, 0);
    check_eq("fd_rdy", bus.ex_ready, 1);
    bus.wb_ready = 1'b1;

    // Reset asserted during WAIT, then recovery
    accept("rw", 2'b00, 32'h0000_0055, 32'h0000_0066, 5'd12);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check_all_zero("rw");
    tick();
    tick();
    reset = 1'b1;
    #1;
    check_eq("rw_rel_rdy", bus.ex_ready, 1);
    accept("rw2", 2'b00, 32'h0000_0002, 32'h0000_0005, 5'd13);
    exp_q.push_back(32'h0000_000A);
    miss_path("rw2", 1'b1, 32'h0000_0002, 32'h0000_0005, 32'h0000_000A, 5'd13);
    wb_take("rw2");

`ifdef MUL_RESULT_CACHE_EN
    // Repeated MULH.WU hits the cache: no start, result one cycle after accept
    accept("cfill", 2'b10, 32'h0000_0003, 32'hFFFF_FFFF, 5'd14);
    exp_q.push_back(32'h0000_0002);
    miss_path("cfill", 1'b0, 32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0002, 5'd14);
    wb_take("cfill");
    s0 = n_start;
    accept("chit", 2'b10, 32'h0000_0003, 32'hFFFF_FFFF, 5'd15);
    exp_q.push_back(32'h0000_0002);
    check_eq("chit_start", bus.mul_start, 0);
    check_eq("chit_wbv",   bus.wb_valid,  1);
    check_eq("chit_data",  bus.wb_data,   32'h0000_0002);
    check_eq("chit_dest",  bus.wb_dest,   15);
    wb_take("chit");
    check_eq("chit_nstart", n_start - s0, 0);
`endif

    // ---------------- report ----------------
    check_eq("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
